// File: rtl/axil_strobe_arbiter_if.sv
// Bundle between the AXI-Lite front end / sub-block targets and the arbiter.
// The arbiter takes the slave view; the front end and targets take the master view.
interface axil_strobe_arbiter_if #(
  parameter int NTGT   = 4,
  parameter int ADDR_W = 18
);
  logic              rstart;
  logic [ADDR_W-1:0] raddr;
  logic              wstart;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata_in;
  logic              rbusy;
  logic              wbusy;
  logic [NTGT-1:0]   tgt_rstr;
  logic [NTGT-1:0]   tgt_wstr;
  logic [NTGT-1:0]   tgt_rack;
  logic [NTGT-1:0]   tgt_wack;
  logic [32*NTGT-1:0] tgt_din;
  logic [7:0]        tgt_addr;
  logic [31:0]       tgt_wdata;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output rstart, raddr, wstart, waddr, wdata_in,
    output tgt_rack, tgt_wack, tgt_din, rready, bready,
    input  rbusy, wbusy, tgt_rstr, tgt_wstr, tgt_addr,
    input  tgt_wdata, rdata, rresp, rvalid, wready,
    input  bresp, bvalid
  );

  modport slave (
    input  rstart, raddr, wstart, waddr, wdata_in,
    input  tgt_rack, tgt_wack, tgt_din, rready, bready,
    output rbusy, wbusy, tgt_rstr, tgt_wstr, tgt_addr,
    output tgt_wdata, rdata, rresp, rvalid, wready,
    output bresp, bvalid
  );
endinterface

// File: rtl/axil_strobe_arbiter.sv
// Read/write arbiter driving one-hot strobes onto a shared sub-block bus,
// with ack/timeout handling and AXI-Lite R/B responses.
module axil_strobe_arbiter #(
  parameter int NTGT    = 4,
  parameter int ADDR_W  = 18,
  parameter int TIMEOUT = 255
) (
  input  logic                 axilClk,
  input  logic                 axilRstN,
  axil_strobe_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD_STB, WR_STB, RD_RSP, WR_RSP
  } state_e;

  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_SLV = 2'b10;
  localparam logic [1:0] RESP_DEC = 2'b11;

  state_e          state_q, state_d;
  logic            rd_pend_q, rd_pend_d;
  logic            wr_pend_q, wr_pend_d;
  logic [11:0]     raddr_q, raddr_d;
  logic [11:0]     waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            last_wr_q, last_wr_d;
  logic [15:0]     timer_q, timer_d;
  logic [3:0]      idx_q, idx_d;
  logic [NTGT-1:0] rstr_q, rstr_d;
  logic [NTGT-1:0] wstr_q, wstr_d;
  logic [7:0]      taddr_q, taddr_d;
  logic [31:0]     twdata_q, twdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            rvalid_q, rvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            bvalid_q, bvalid_d;
  logic            wready_q, wready_d;

  logic            ack_r, ack_w;
  logic [31:0]     din_sel;
  logic [3:0]      ridx, widx;
  logic            rmap, wmap;
  logic            pick_rd, pick_wr;
  logic            tmo;
  logic            unused_addr;

  assign unused_addr = ^{bus.raddr[ADDR_W-1:12],
                         bus.waddr[ADDR_W-1:12]};

  assign ridx = raddr_q[11:8];
  assign widx = waddr_q[11:8];
  assign rmap = {1'b0, ridx} < 5'(NTGT);
  assign wmap = {1'b0, widx} < 5'(NTGT);
  assign tmo  = timer_q == 16'(TIMEOUT);

  // Contention alternates against the last contested winner only.
  assign pick_rd = rd_pend_q & (~wr_pend_q | last_wr_q);
  assign pick_wr = wr_pend_q & (~rd_pend_q | ~last_wr_q);

  always_comb begin
    ack_r   = 1'b0;
    ack_w   = 1'b0;
    din_sel = '0;
    for (int i = 0; i < NTGT; i++) begin
      if (idx_q == 4'(i)) begin
        ack_r   = bus.tgt_rack[i];
        ack_w   = bus.tgt_wack[i];
        din_sel = bus.tgt_din[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_pend_d = rd_pend_q;
    wr_pend_d = wr_pend_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    last_wr_d = last_wr_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    rstr_d    = rstr_q;
    wstr_d    = wstr_q;
    taddr_d   = taddr_q;
    twdata_d  = twdata_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rvalid_d  = rvalid_q;
    bresp_d   = bresp_q;
    bvalid_d  = bvalid_q;
    wready_d  = 1'b0;

    if (bus.rstart && !rd_pend_q) begin
      rd_pend_d = 1'b1;
      raddr_d   = bus.raddr[11:0];
    end
    if (bus.wstart && !wr_pend_q) begin
      wr_pend_d = 1'b1;
      waddr_d   = bus.waddr[11:0];
      wdata_d   = bus.wdata_in;
      wready_d  = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (rd_pend_q && wr_pend_q)
          last_wr_d = pick_wr;
        unique case (1'b1)
          pick_rd: begin
            timer_d = '0;
            idx_d   = ridx;
            if (rmap) begin
              state_d = RD_STB;
              rstr_d  = NTGT'(1) << ridx;
              taddr_d = raddr_q[7:0];
            end else begin
              state_d  = RD_RSP;
              rdata_d  = '0;
              rresp_d  = RESP_DEC;
              rvalid_d = 1'b1;
            end
          end
          pick_wr: begin
            timer_d = '0;
            idx_d   = widx;
            if (wmap) begin
              state_d  = WR_STB;
              wstr_d   = NTGT'(1) << widx;
              taddr_d  = waddr_q[7:0];
              twdata_d = wdata_q;
            end else begin
              state_d  = WR_RSP;
              bresp_d  = RESP_DEC;
              bvalid_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
      RD_STB: begin
        if (timer_q != 16'hFFFF)
          timer_d = timer_q + 16'd1;
        if (ack_r) begin
          state_d  = RD_RSP;
          rstr_d   = '0;
          rdata_d  = din_sel;
          rresp_d  = RESP_OK;
          rvalid_d = 1'b1;
        end else if (tmo) begin
          state_d  = RD_RSP;
          rstr_d   = '0;
          rdata_d  = 32'hDEADBEEF;
          rresp_d  = RESP_SLV;
          rvalid_d = 1'b1;
        end
      end
      WR_STB: begin
        if (timer_q != 16'hFFFF)
          timer_d = timer_q + 16'd1;
        if (ack_w) begin
          state_d  = WR_RSP;
          wstr_d   = '0;
          bresp_d  = RESP_OK;
          bvalid_d = 1'b1;
        end else if (tmo) begin
          state_d  = WR_RSP;
          wstr_d   = '0;
          bresp_d  = RESP_SLV;
          bvalid_d = 1'b1;
        end
      end
      RD_RSP: begin
        if (bus.rready) begin
          state_d   = IDLE;
          rvalid_d  = 1'b0;
          rd_pend_d = 1'b0;
        end
      end
      WR_RSP: begin
        if (bus.bready) begin
          state_d   = IDLE;
          bvalid_d  = 1'b0;
          wr_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axilClk or negedge axilRstN) begin
    if (!axilRstN) begin
      state_q   <= IDLE;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      last_wr_q <= 1'b1;
      timer_q   <= '0;
      idx_q     <= '0;
      rstr_q    <= '0;
      wstr_q    <= '0;
      taddr_q   <= '0;
      twdata_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rvalid_q  <= 1'b0;
      bresp_q   <= '0;
      bvalid_q  <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      last_wr_q <= last_wr_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      rstr_q    <= rstr_d;
      wstr_q    <= wstr_d;
      taddr_q   <= taddr_d;
      twdata_q  <= twdata_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      bvalid_q  <= bvalid_d;
      wready_q  <= wready_d;
    end
  end

  assign bus.rbusy     = rd_pend_q;
  assign bus.wbusy     = wr_pend_q;
  assign bus.tgt_rstr  = rstr_q;
  assign bus.tgt_wstr  = wstr_q;
  assign bus.tgt_addr  = taddr_q;
  assign bus.tgt_wdata = twdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.rresp     = rresp_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.bresp     = bresp_q;
  assign bus.bvalid    = bvalid_q;
  assign bus.wready    = wready_q;

endmodule

// File: tb/tb_axil_strobe_arbiter.sv
// Directed bench: reads, writes, contention, unmapped, timeout
// and mid-transaction reset against hand-computed expectations.
module tb_axil_strobe_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [3:0]  ack_en = 4'hF;
  int          ack_dly = 0;
  int          cnt = 0;

  int          rstr_cyc = 0;
  int          wstr_cyc = 0;
  int          viol = 0;
  logic [3:0]  order_log = '0;
  logic [7:0]  last_taddr = '0;
  logic [31:0] last_twd = '0;
  logic [3:0]  last_wbits = '0;
  logic [3:0]  prev_stb = '0;
  logic [7:0]  prev_addr = '0;
  logic [31:0] prev_wd = '0;
  int          lat;

  axil_strobe_arbiter_if #(.NTGT(4), .ADDR_W(18)) bus ();

  axil_strobe_arbiter #(
    .NTGT(4), .ADDR_W(18), .TIMEOUT(8)
  ) dut (
    .axilClk (clk),
    .axilRstN(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.tgt_din = {32'h3333_0003, 32'h2222_0002,
                        32'hCAFE_0001, 32'h1111_0000};
  assign bus.tgt_rack = bus.tgt_rstr & ack_en
                        & {4{cnt == ack_dly}};
  assign bus.tgt_wack = bus.tgt_wstr & ack_en
                        & {4{cnt == ack_dly}};

  always @(posedge clk)
    cnt <= ((bus.tgt_rstr | bus.tgt_wstr) != 0) ? cnt + 1 : 0;

  always @(negedge clk) begin
    logic [3:0] stb;
    stb = bus.tgt_rstr | bus.tgt_wstr;
    if ($countones(stb) > 1) viol++;
    if (stb != 0 && prev_stb != 0 &&
        (bus.tgt_addr !== prev_addr || bus.tgt_wdata !== prev_wd))
      viol++;
    if (bus.tgt_rstr != 0) rstr_cyc++;
    if (bus.tgt_wstr != 0) begin
      wstr_cyc++;
      last_wbits = bus.tgt_wstr;
      last_twd   = bus.tgt_wdata;
    end
    if (stb != 0) last_taddr = bus.tgt_addr;
    if (stb != 0 && prev_stb == 0)
      order_log = {order_log[1:0],
                   (bus.tgt_rstr != 0) ? 2'b01 : 2'b10};
    prev_stb  = stb;
    prev_addr = bus.tgt_addr;
    prev_wd   = bus.tgt_wdata;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rstr_cyc  = 0;
    wstr_cyc  = 0;
    order_log = '0;
  endtask

  task automatic start_rd(input logic [17:0] a);
    bus.raddr  = a;
    bus.rstart = 1'b1;
    @(negedge clk);
    bus.rstart = 1'b0;
  endtask

  task automatic start_wr(input logic [17:0] a,
                          input logic [31:0] d);
    bus.waddr    = a;
    bus.wdata_in = d;
    bus.wstart   = 1'b1;
    @(negedge clk);
    bus.wstart   = 1'b0;
  endtask

  task automatic wait_rv(output int n);
    n = 1;
    while (!bus.rvalid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rvalid) chk("rvalid_timeout", 0, 1);
  endtask

  task automatic wait_bv(output int n);
    n = 1;
    while (!bus.bvalid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.bvalid) chk("bvalid_timeout", 0, 1);
  endtask

  task automatic take_r();
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    chk("rvalid_drop", 32'(bus.rvalid), 0);
    chk("rbusy_drop", 32'(bus.rbusy), 0);
  endtask

  task automatic take_b();
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    chk("bvalid_drop", 32'(bus.bvalid), 0);
    chk("wbusy_drop", 32'(bus.wbusy), 0);
  endtask

  task automatic pair(input logic [3:0] exp_order);
    int n;
    clr();
    bus.raddr    = 18'h00003;
    bus.waddr    = 18'h00320;
    bus.wdata_in = 32'h0BAD_F00D;
    bus.rstart   = 1'b1;
    bus.wstart   = 1'b1;
    @(negedge clk);
    bus.rstart = 1'b0;
    bus.wstart = 1'b0;
    n = 0;
    while ((bus.rbusy || bus.wbusy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("pair_done", 32'(bus.rbusy | bus.wbusy), 0);
    chk("pair_order", 32'(order_log), 32'(exp_order));
  endtask

  initial begin
    bus.rstart   = 1'b0;
    bus.wstart   = 1'b0;
    bus.raddr    = '0;
    bus.waddr    = '0;
    bus.wdata_in = '0;
    bus.rready   = 1'b0;
    bus.bready   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ctl", {20'd0, bus.rbusy, bus.wbusy, bus.rvalid,
        bus.bvalid, bus.wready, bus.rresp, bus.bresp,
        bus.tgt_rstr | bus.tgt_wstr}, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_taddr", {24'd0, bus.tgt_addr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // mapped read, ack in strobe cycle 3
    clr();
    ack_dly = 3;
    start_rd(18'h00105);
    wait_rv(lat);
    chk("rd_lat", lat, 6);
    chk("rd_data", bus.rdata, 32'hCAFE0001);
    chk("rd_resp", 32'(bus.rresp), 0);
    chk("rd_stb_w", rstr_cyc, 4);
    chk("rd_taddr", 32'(last_taddr), 32'h05);
    start_rd(18'h00200);
    repeat (2) @(negedge clk);
    chk("rd_hold", 32'(bus.rvalid), 1);
    take_r();
    repeat (3) @(negedge clk);
    chk("rd_drop_busy", rstr_cyc, 4);

    // mapped write, immediate ack
    clr();
    ack_dly = 0;
    start_wr(18'h00210, 32'h12345678);
    chk("wready_pulse", 32'(bus.wready), 1);
    @(negedge clk);
    chk("wready_low", 32'(bus.wready), 0);
    wait_bv(lat);
    chk("wr_stb_w", wstr_cyc, 1);
    chk("wr_bits", 32'(last_wbits), 32'h4);
    chk("wr_wdata", last_twd, 32'h12345678);
    chk("wr_taddr", 32'(last_taddr), 32'h10);
    chk("wr_resp", 32'(bus.bresp), 0);
    take_b();

    // contention alternates
    ack_dly    = 1;
    bus.rready = 1'b1;
    bus.bready = 1'b1;
    pair(4'b0110);
    pair(4'b1001);
    bus.rready = 1'b0;
    bus.bready = 1'b0;
    @(negedge clk);

    // unmapped read and write
    clr();
    start_rd(18'h00F00);
    wait_rv(lat);
    chk("dec_lat", lat, 2);
    chk("dec_rresp", 32'(bus.rresp), 3);
    chk("dec_rdata", bus.rdata, 0);
    take_r();
    start_wr(18'h00400, 32'h5A5A5A5A);
    wait_bv(lat);
    chk("dec_bresp", 32'(bus.bresp), 3);
    take_b();
    chk("dec_no_stb", rstr_cyc + wstr_cyc, 0);

    // read timeout
    clr();
    ack_en = 4'b0111;
    start_rd(18'h00301);
    wait_rv(lat);
    chk("tmo_lat", lat, 11);
    chk("tmo_stb_w", rstr_cyc, 9);
    chk("tmo_rresp", 32'(bus.rresp), 2);
    chk("tmo_rdata", bus.rdata, 32'hDEADBEEF);
    take_r();

    // reset while write strobe is high
    ack_en = 4'b0000;
    start_wr(18'h00220, 32'hAAAA5555);
    lat = 0;
    while (bus.tgt_wstr == 0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("mid_wstr_up", 32'(bus.tgt_wstr), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {26'd0, bus.tgt_wstr != 0, bus.tgt_rstr != 0,
        bus.bvalid, bus.rvalid, bus.wbusy, bus.rbusy}, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    ack_en  = 4'hF;
    ack_dly = 2;
    @(negedge clk);
    start_rd(18'h00107);
    wait_rv(lat);
    chk("post_lat", lat, 5);
    chk("post_rdata", bus.rdata, 32'hCAFE0001);
    chk("post_rresp", 32'(bus.rresp), 0);
    take_r();

    chk("onehot_stable", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
